// File: rtl/pellet_renderer.sv
// Pellet renderer: prefetches one maze tile row from the pellet map during hblank and
// emits registered per-pixel pellet/power-pellet enables. `PELLET_BLINK_EN enables power-pellet blinking.
module pellet_renderer #(
  parameter logic [9:0] MAZE_X0 = 10'd96,
  parameter logic [9:0] MAZE_Y0 = 10'd16,
  parameter logic [9:0] FETCH_X = 10'd640,
  parameter logic [9:0] H_LINES = 10'd525
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       frame_clk,
  output logic [4:0] read_row,
  output logic [4:0] read_col,
  input  logic       pellet_data,
  output logic       pellet_on,
  output logic       power_on,
  output logic       fetch_busy
);

  localparam int unsigned COL_W    = 5;
  localparam int unsigned ROW_W    = 7;
  localparam int unsigned COLS     = 28;
  localparam int unsigned LAST_COL = COLS - 1;
  localparam logic signed [10:0] MAZE_W = 11'sd224;
  localparam logic signed [10:0] MAZE_H = 11'sd248;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t             r_state, w_state_nxt;
  logic [COL_W-1:0]   r_read_row, w_row_nxt;
  logic [COL_W-1:0]   r_read_col, w_col_nxt;
  logic [COLS-1:0]    r_linebuf, w_linebuf_nxt;
  logic               r_pellet_on, r_power_on, r_fetch_busy;

  // Current-pixel geometry relative to the maze origin
  logic signed [10:0] w_tx, w_ty;
  logic               w_in_maze;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic [2:0]         w_px, w_py;
  logic               w_pwr_tile, w_lb_bit, w_dot_shape, w_pwr_shape, w_blink_vis;

  assign w_tx      = $signed({1'b0, DrawX}) - $signed({1'b0, MAZE_X0});
  assign w_ty      = $signed({1'b0, DrawY}) - $signed({1'b0, MAZE_Y0});
  assign w_in_maze = (w_tx >= 11'sd0) && (w_tx < MAZE_W) && (w_ty >= 11'sd0) && (w_ty < MAZE_H);
  assign w_col     = w_tx[7:3];
  assign w_row     = w_ty[9:3];
  assign w_px      = w_tx[2:0];
  assign w_py      = w_ty[2:0];

  assign w_pwr_tile  = ((w_row == 7'd3) || (w_row == 7'd23)) &&
                       ((w_col == 5'd1) || (w_col == 5'd26));
  assign w_lb_bit    = r_linebuf[w_col];
  assign w_dot_shape = ((w_px == 3'd3) || (w_px == 3'd4)) && ((w_py == 3'd3) || (w_py == 3'd4));
  assign w_pwr_shape = (w_px >= 3'd1) && (w_px <= 3'd6) && (w_py >= 3'd1) && (w_py <= 3'd6);

  // Next scanline (with frame wrap) and its tile row
  logic [9:0]         w_ny_inc, w_ny;
  logic signed [10:0] w_nty;
  logic               w_ny_in;
  logic [COL_W-1:0]   w_nrow;

  assign w_ny_inc = DrawY + 10'd1;
  assign w_ny     = (w_ny_inc == H_LINES) ? 10'd0 : w_ny_inc;
  assign w_nty    = $signed({1'b0, w_ny}) - $signed({1'b0, MAZE_Y0});
  assign w_ny_in  = (w_nty >= 11'sd0) && (w_nty < MAZE_H);
  assign w_nrow   = w_nty[7:3];

  // Blink control
`ifdef PELLET_BLINK_EN
  logic [3:0] r_blink_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= 4'd0;
    end else if (frame_clk) begin
      r_blink_cnt <= r_blink_cnt + 4'd1;
    end
  end

  assign w_blink_vis = ~r_blink_cnt[3];
`else
  logic w_unused_frame_clk;
  assign w_unused_frame_clk = frame_clk;
  assign w_blink_vis        = 1'b1;
`endif

  // Prefetch FSM state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_read_row   <= '0;
      r_read_col   <= '0;
      r_linebuf    <= '0;
      r_fetch_busy <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read_row   <= w_row_nxt;
      r_read_col   <= w_col_nxt;
      r_linebuf    <= w_linebuf_nxt;
      r_fetch_busy <= (w_state_nxt == S_FETCH);
    end
  end

  // Next-state logic; a trigger while fetching is ignored because only IDLE looks at DrawX
  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_read_row;
    w_col_nxt     = r_read_col;
    w_linebuf_nxt = r_linebuf;
    case (r_state)
      S_IDLE: begin
        if (DrawX == FETCH_X) begin
          if (w_ny_in) begin
            w_row_nxt   = w_nrow;
            w_col_nxt   = '0;
            w_state_nxt = S_FETCH;
          end else begin
            w_linebuf_nxt = '0;
          end
        end
      end
      S_FETCH: begin
        w_linebuf_nxt[r_read_col] = pellet_data;
        if (r_read_col == COL_W'(LAST_COL)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_col_nxt = r_read_col + 5'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered pixel enables (one cycle behind DrawX/DrawY)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pellet_on <= 1'b0;
      r_power_on  <= 1'b0;
    end else begin
      r_pellet_on <= w_in_maze & ~w_pwr_tile & w_lb_bit & w_dot_shape;
      r_power_on  <= w_in_maze & w_pwr_tile & w_lb_bit & w_pwr_shape & w_blink_vis;
    end
  end

  assign read_row   = r_read_row;
  assign read_col   = r_read_col;
  assign pellet_on  = r_pellet_on;
  assign power_on   = r_power_on;
  assign fetch_busy = r_fetch_busy;

endmodule
